// File: rtl/host_bridge_pkg.sv
// Shared types and constants for the host word bridge and its read deserializer.
package host_bridge_pkg;

  localparam int WORDSZ_DEF   = 384;
  localparam int PORTW_DEF    = 64;
  localparam int PORTAW_DEF   = 16;
  localparam int RFSZLOG2_DEF = 11;
  localparam int CORELOG2_DEF = 2;
  localparam int FUNCIDW_DEF  = 6;
  localparam int RD_TMO_DEF   = 16;

  // Beat index occupies the low BEAT_SHIFT bits of a device port address.
  localparam int BEAT_SHIFT = 5;
  localparam int BEATW      = BEAT_SHIFT;

  function automatic int ser_size(input int wsz, input int pw);
    return (wsz + pw - 1) / pw;
  endfunction

  localparam int SERSZ = ser_size(WORDSZ_DEF, PORTW_DEF);

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_START = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DRAIN = 3'd3,
    S_ST_START = 3'd4,
    S_ST_WAIT  = 3'd5,
    S_RSP      = 3'd6
  } state_e;

endpackage

// File: rtl/word_deser.sv
// Collects in-order device read beats into one operand word. Beats arriving
// after the word is complete are dropped; the buffer restarts on i_clear.
module word_deser
  import host_bridge_pkg::*;
#(
  parameter int WORDSZ = WORDSZ_DEF,
  parameter int PORTW  = PORTW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_beat_valid,
  input  logic [PORTW-1:0]  i_beat_data,
  output logic [WORDSZ-1:0] o_word,
  output logic              o_done
);

  localparam int NBEAT = ser_size(WORDSZ, PORTW);
  localparam int PADW  = NBEAT * PORTW;
  localparam int CNTW  = $clog2(NBEAT + 1);

  logic [PADW-1:0] r_buf;
  logic [CNTW-1:0] r_cnt;
  logic            w_take;

  assign w_take = i_beat_valid && (r_cnt != CNTW'(NBEAT));

  // Beat counter and assembly buffer; k-th accepted beat lands in slot k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_buf[int'(r_cnt)*PORTW +: PORTW] <= i_beat_data;
      r_cnt                             <= r_cnt + CNTW'(1);
    end
  end

  // Padding above WORDSZ in the last beat is simply not exported.
  assign o_word = r_buf[WORDSZ-1:0];
  assign o_done = (r_cnt == CNTW'(NBEAT));

endmodule

// File: rtl/host_word_bridge.sv
// Host-side word command front end for micro_top: serializes writes into
// port beats, issues read bursts and reassembles the reply, and runs the
// start/busy handshake. One command in flight, one response per command.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a command; cmd_ready when device not busy
// S_WR       | one write beat per cycle; bcast walks chip_sel 0..CORE_NUM-1
// S_RD_ISSUE | one ren beat per cycle; returning beats already captured
// S_RD_DRAIN | waiting for remaining beats, bounded by RD_TMO
// S_ST_START | start held high until busy is observed
// S_ST_WAIT  | waiting for busy to fall
// S_RSP      | response presented until rsp_ready
module host_word_bridge
  import host_bridge_pkg::*;
#(
  parameter int WORDSZ   = WORDSZ_DEF,
  parameter int PORTW    = PORTW_DEF,
  parameter int PORTAW   = PORTAW_DEF,
  parameter int RFSZLOG2 = RFSZLOG2_DEF,
  parameter int CORELOG2 = CORELOG2_DEF,
  parameter int FUNCIDW  = FUNCIDW_DEF,
  parameter int RD_TMO   = RD_TMO_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic                i_cmd_bcast,
  input  logic [CORELOG2-1:0] i_cmd_core,
  input  logic [RFSZLOG2-1:0] i_cmd_addr,
  input  logic [WORDSZ-1:0]   i_cmd_wdata,
  input  logic [FUNCIDW-1:0]  i_cmd_funcid,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WORDSZ-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  output logic [CORELOG2-1:0] o_chip_sel,
  output logic [FUNCIDW-1:0]  o_funcid,
  output logic                o_start,
  output logic                o_wen,
  output logic [PORTAW-1:0]   o_waddr,
  output logic [PORTW-1:0]    o_wdata,
  output logic                o_ren,
  output logic [PORTAW-1:0]   o_raddr,
  input  logic [PORTW-1:0]    i_rdata,
  input  logic                i_rdata_valid,
  input  logic                i_busy
);

  // Beat index must fit in BEAT_SHIFT bits, so ser_size(WORDSZ, PORTW) <= 32.
  localparam int NBEAT    = ser_size(WORDSZ, PORTW);
  localparam int PADW     = NBEAT * PORTW;
  localparam int CORE_NUM = 1 << CORELOG2;
  localparam int TMOW     = $clog2(RD_TMO + 1);

  localparam logic [BEATW-1:0]    LASTB     = BEATW'(NBEAT - 1);
  localparam logic [CORELOG2-1:0] LAST_CORE = CORELOG2'(CORE_NUM - 1);

  state_e                r_state;
  logic                  r_live;
  logic                  r_bcast;
  logic [RFSZLOG2-1:0]   r_addr;
  logic [PADW-1:0]       r_word;
  logic [BEATW-1:0]      r_beat;
  logic [TMOW-1:0]       r_tmo;

  logic                  r_wen;
  logic [PORTAW-1:0]     r_waddr;
  logic [PORTW-1:0]      r_wdata;
  logic                  r_ren;
  logic [PORTAW-1:0]     r_raddr;
  logic [CORELOG2-1:0]   r_chip_sel;
  logic [FUNCIDW-1:0]    r_funcid;
  logic                  r_start;
  logic                  r_rsp_valid;
  logic [WORDSZ-1:0]     r_rsp_data;
  logic                  r_rsp_err;

  logic                  w_cmd_ready;
  logic                  w_accept;
  op_e                   w_op;
  logic [PADW-1:0]       w_cmd_pad;
  logic [BEATW-1:0]      w_beat_nx;
  logic                  w_cap;
  logic [WORDSZ-1:0]     w_rd_word;
  logic                  w_rd_done;

  function automatic logic [PORTAW-1:0] beat_addr(input logic [RFSZLOG2-1:0] a,
                                                   input logic [BEATW-1:0]    b);
    return (PORTAW'(a) << BEAT_SHIFT) + PORTAW'(b);
  endfunction

  // r_live keeps cmd_ready low while reset is asserted.
  assign w_cmd_ready = r_live && (r_state == S_IDLE) && !i_busy;
  assign w_accept    = i_cmd_valid && w_cmd_ready;
  assign w_op        = op_e'(i_cmd_op);
  assign w_cmd_pad   = PADW'(i_cmd_wdata);
  assign w_beat_nx   = r_beat + BEATW'(1);
  assign w_cap       = i_rdata_valid && ((r_state == S_RD_ISSUE) || (r_state == S_RD_DRAIN));

  word_deser #(
    .WORDSZ (WORDSZ),
    .PORTW  (PORTW)
  ) u_deser (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_accept),
    .i_beat_valid (w_cap),
    .i_beat_data  (i_rdata),
    .o_word       (w_rd_word),
    .o_done       (w_rd_done)
  );

  // Command FSM with all device- and host-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_live      <= 1'b0;
      r_bcast     <= 1'b0;
      r_addr      <= '0;
      r_word      <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_ren       <= 1'b0;
      r_raddr     <= '0;
      r_chip_sel  <= '0;
      r_funcid    <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bcast <= i_cmd_bcast;
            r_addr  <= i_cmd_addr;
            r_word  <= w_cmd_pad;
            r_beat  <= '0;
            case (w_op)
              OP_WRITE: begin
                r_state    <= S_WR;
                r_chip_sel <= i_cmd_bcast ? '0 : i_cmd_core;
                r_wen      <= 1'b1;
                r_waddr    <= beat_addr(i_cmd_addr, '0);
                r_wdata    <= w_cmd_pad[PORTW-1:0];
              end
              OP_READ: begin
                r_state    <= S_RD_ISSUE;
                r_chip_sel <= i_cmd_core;
                r_ren      <= 1'b1;
                r_raddr    <= beat_addr(i_cmd_addr, '0);
              end
              OP_START: begin
                r_state    <= S_ST_START;
                r_chip_sel <= i_cmd_core;
                r_funcid   <= i_cmd_funcid;
                r_start    <= 1'b1;
              end
              OP_RSVD: begin
                r_state     <= S_RSP;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        S_WR: begin
          if (r_beat != LASTB) begin
            r_beat  <= w_beat_nx;
            r_waddr <= beat_addr(r_addr, w_beat_nx);
            r_wdata <= r_word[int'(w_beat_nx)*PORTW +: PORTW];
          end else if (r_bcast && (r_chip_sel != LAST_CORE)) begin
            // Next core starts on the very next cycle: no gap between cores.
            r_chip_sel <= r_chip_sel + CORELOG2'(1);
            r_beat     <= '0;
            r_waddr    <= beat_addr(r_addr, '0);
            r_wdata    <= r_word[PORTW-1:0];
          end else begin
            r_wen       <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
          end
        end

        S_RD_ISSUE: begin
          if (r_beat != LASTB) begin
            r_beat  <= w_beat_nx;
            r_raddr <= beat_addr(r_addr, w_beat_nx);
          end else begin
            r_ren   <= 1'b0;
            r_raddr <= '0;
            r_tmo   <= TMOW'(RD_TMO - 1);
            r_state <= S_RD_DRAIN;
          end
        end

        S_RD_DRAIN: begin
          if (w_rd_done) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_word;
            r_rsp_err   <= 1'b0;
          end else if (r_tmo == '0) begin
            // Missing beats stay zero in the deserializer buffer.
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_word;
            r_rsp_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo - TMOW'(1);
          end
        end

        S_ST_START: begin
          if (i_busy) begin
            r_start  <= 1'b0;
            r_funcid <= '0;
            r_state  <= S_ST_WAIT;
          end
        end

        S_ST_WAIT: begin
          if (!i_busy) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
          end
        end

        S_RSP: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = w_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_chip_sel  = r_chip_sel;
  assign o_funcid    = r_funcid;
  assign o_start     = r_start;
  assign o_wen       = r_wen;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_ren       = r_ren;
  assign o_raddr     = r_raddr;

endmodule
